// File: rtl/mac_pkg.sv
// mac_pkg: shared word layout, FSM encodings and default depth for the transmit frame FIFO.
package mac_pkg;
   localparam int START_BIT          = 8;
   localparam int END_BIT            = 9;
   localparam int WORD_WIDTH         = 10;
   localparam int DEFAULT_ADDR_WIDTH = 11;
   typedef enum logic {WR_IDLE, WR_FRAME} wr_state_e;
   typedef enum logic {RD_IDLE, RD_FRAME} rd_state_e;
endpackage

// File: rtl/tx_frame_fifo_if.sv
// tx_frame_fifo_if: host write bus and tx_sm read bus of the transmit frame FIFO.
interface tx_frame_fifo_if;
   logic [7:0] wr_data;
   logic       wr_start;
   logic       wr_end;
   logic       wr_en;
   logic       wr_full;
   logic       wr_dropped;
   logic [7:0] fifo_data;
   logic       fifo_data_start;
   logic       fifo_data_end;
   logic       fifo_data_available;
   logic       fifo_data_read;
   logic       fifo_retry;
   modport master (
      output wr_data, wr_start, wr_end, wr_en, fifo_data_read, fifo_retry,
      input  wr_full, wr_dropped, fifo_data, fifo_data_start, fifo_data_end, fifo_data_available
   );
   modport slave (
      input  wr_data, wr_start, wr_end, wr_en, fifo_data_read, fifo_retry,
      output wr_full, wr_dropped, fifo_data, fifo_data_start, fifo_data_end, fifo_data_available
   );
endinterface

// File: rtl/tx_fifo_ram.sv
// tx_fifo_ram: simple dual-port word store, synchronous write and combinational (show-ahead) read.
module tx_fifo_ram
   import mac_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WORD_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WORD_WIDTH-1:0] rdata
);
   logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/tx_frame_fifo.sv
// tx_frame_fifo: frame-aware transmit buffer with commit-on-end, retry rewind and overflow discard.
// Defining TX_FIFO_STATS_EN adds stat_frames_sent / stat_retries counters.
module tx_frame_fifo
   import mac_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
   parameter int FRAME_CNT_WIDTH = 6
) (
   input  logic               clock,
   input  logic               reset,
   tx_frame_fifo_if.slave     bus
`ifdef TX_FIFO_STATS_EN
   ,
   output logic [15:0]        stat_frames_sent,
   output logic [15:0]        stat_retries
`endif
);
   localparam int PW = ADDR_WIDTH + 1;
   typedef logic [PW-1:0] ptr_t;
   localparam ptr_t PTR_ONE = ptr_t'(1);
   localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE = FRAME_CNT_WIDTH'(1);

   wr_state_e                  wr_state_q, wr_state_d;
   rd_state_e                  rd_state_q, rd_state_d;
   ptr_t                       wr_ptr_q, wr_ptr_d, wr_commit_ptr_q, wr_commit_ptr_d;
   ptr_t                       rd_ptr_q, rd_ptr_d, rd_frame_ptr_q, rd_frame_ptr_d;
   ptr_t                       rd_release_ptr_q, rd_release_ptr_d;
   logic                       wr_dropped_q, wr_dropped_d;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
   ptr_t                       wr_base, wr_next;
   logic [WORD_WIDTH-1:0]      rd_word;
   logic                       full, avail, mem_we, commit, rel, retry_ok, rd_ok;

   tx_fifo_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clock (clock),
      .we    (mem_we),
      .waddr (wr_base[ADDR_WIDTH-1:0]),
      .wdata ({bus.wr_end, bus.wr_start, bus.wr_data}),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (rd_word)
   );

   // Full is judged against the release pointer so a frame still open for retry is never overwritten.
   assign full = (wr_ptr_q[ADDR_WIDTH] != rd_release_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_release_ptr_q[ADDR_WIDTH-1:0]);
   assign avail    = frame_count_q != '0;
   assign retry_ok = bus.fifo_retry && (rd_state_q == RD_FRAME);
   assign rd_ok    = bus.fifo_data_read && avail && !retry_ok;
   assign rel      = rd_ok && rd_word[END_BIT];
   // A start while a frame is open rewrites from the last commit point.
   assign wr_base  = (wr_state_q == WR_FRAME && bus.wr_start) ? wr_commit_ptr_q : wr_ptr_q;
   assign wr_next  = wr_base + PTR_ONE;

   always_comb begin
      wr_state_d      = wr_state_q;
      wr_ptr_d        = wr_ptr_q;
      wr_commit_ptr_d = wr_commit_ptr_q;
      wr_dropped_d    = 1'b0;
      mem_we          = 1'b0;
      commit          = 1'b0;
      if (bus.wr_en && wr_state_q == WR_FRAME && full) begin
         wr_ptr_d     = wr_commit_ptr_q;
         wr_dropped_d = 1'b1;
         wr_state_d   = WR_IDLE;
      end else if (bus.wr_en && !full && (wr_state_q == WR_FRAME || bus.wr_start)) begin
         mem_we          = 1'b1;
         wr_ptr_d        = wr_next;
         wr_dropped_d    = (wr_state_q == WR_FRAME) && bus.wr_start;
         commit          = bus.wr_end;
         wr_commit_ptr_d = bus.wr_end ? wr_next : wr_commit_ptr_q;
         wr_state_d      = bus.wr_end ? WR_IDLE : WR_FRAME;
      end
   end

   always_comb begin
      rd_state_d       = rd_state_q;
      rd_ptr_d         = rd_ptr_q;
      rd_frame_ptr_d   = rd_frame_ptr_q;
      rd_release_ptr_d = rd_release_ptr_q;
      if (retry_ok) begin
         rd_ptr_d   = rd_frame_ptr_q;
         rd_state_d = RD_IDLE;
      end else if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (rd_word[START_BIT]) begin
            rd_frame_ptr_d = rd_ptr_q;
            rd_state_d     = RD_FRAME;
         end
         if (rd_word[END_BIT]) begin
            rd_release_ptr_d = rd_ptr_q + PTR_ONE;
            rd_state_d       = RD_IDLE;
         end
      end
      frame_count_d = (commit && !rel && frame_count_q != '1) ? frame_count_q + CNT_ONE :
                      (rel && !commit)                        ? frame_count_q - CNT_ONE :
                                                                frame_count_q;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wr_state_q       <= WR_IDLE;
         rd_state_q       <= RD_IDLE;
         wr_ptr_q         <= '0;
         wr_commit_ptr_q  <= '0;
         rd_ptr_q         <= '0;
         rd_frame_ptr_q   <= '0;
         rd_release_ptr_q <= '0;
         wr_dropped_q     <= 1'b0;
         frame_count_q    <= '0;
      end else begin
         wr_state_q       <= wr_state_d;
         rd_state_q       <= rd_state_d;
         wr_ptr_q         <= wr_ptr_d;
         wr_commit_ptr_q  <= wr_commit_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         rd_frame_ptr_q   <= rd_frame_ptr_d;
         rd_release_ptr_q <= rd_release_ptr_d;
         wr_dropped_q     <= wr_dropped_d;
         frame_count_q    <= frame_count_d;
      end

   assign bus.wr_full             = full;
   assign bus.wr_dropped          = wr_dropped_q;
   assign bus.fifo_data           = rd_word[7:0];
   assign bus.fifo_data_start     = rd_word[START_BIT];
   assign bus.fifo_data_end       = rd_word[END_BIT];
   assign bus.fifo_data_available = avail;

`ifdef TX_FIFO_STATS_EN
   logic [15:0] stat_frames_sent_q, stat_frames_sent_d, stat_retries_q, stat_retries_d;
   always_comb begin
      stat_frames_sent_d = stat_frames_sent_q + 16'(rel);
      stat_retries_d     = stat_retries_q + 16'(retry_ok);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         stat_frames_sent_q <= '0;
         stat_retries_q     <= '0;
      end else begin
         stat_frames_sent_q <= stat_frames_sent_d;
         stat_retries_q     <= stat_retries_d;
      end
   assign stat_frames_sent = stat_frames_sent_q;
   assign stat_retries     = stat_retries_q;
`endif
endmodule

// File: tb/tb_tx_frame_fifo.sv
// tb_tx_frame_fifo: directed checks of the transmit frame FIFO at default depth and at a 16-word depth.
module tb_tx_frame_fifo;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   assertions = 0;
   int   failures   = 0;

   tx_frame_fifo_if bi ();
   tx_frame_fifo_if bs ();

`ifdef TX_FIFO_STATS_EN
   logic [15:0] sent_i, retries_i, sent_s, retries_s;
`endif

   tx_frame_fifo dut (
      .clock (clock),
      .reset (reset),
      .bus   (bi.slave)
`ifdef TX_FIFO_STATS_EN
      ,
      .stat_frames_sent (sent_i),
      .stat_retries     (retries_i)
`endif
   );

   tx_frame_fifo #(.ADDR_WIDTH(4)) dut_s (
      .clock (clock),
      .reset (reset),
      .bus   (bs.slave)
`ifdef TX_FIFO_STATS_EN
      ,
      .stat_frames_sent (sent_s),
      .stat_retries     (retries_s)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Writes bytes [first,last) of an n-byte frame whose byte i is seed+i.
   task automatic wr_bytes(input int n, input logic [7:0] seed, input int first, input int last);
      for (int i = first; i < last; i++) begin
         bi.wr_en    = 1'b1;
         bi.wr_start = (i == 0);
         bi.wr_end   = (i == n - 1);
         bi.wr_data  = seed + 8'(i);
         tick();
      end
      bi.wr_en    = 1'b0;
      bi.wr_start = 1'b0;
      bi.wr_end   = 1'b0;
   endtask

   // Reads bytes [first,last) of an n-byte frame and checks data and flags before each read.
   task automatic rd_bytes(input string tag, input int n, input logic [7:0] seed, input int first, input int last);
      logic [9:0] exp;
      for (int i = first; i < last; i++) begin
         exp = {(i == n - 1), (i == 0), seed + 8'(i)};
         assertions++;
         if ({bi.fifo_data_end, bi.fifo_data_start, bi.fifo_data} !== exp) begin
            failures++;
            $display("FAIL %s byte %0d: got end/start/data %b/%b/%h, want %b/%b/%h", tag, i,
                     bi.fifo_data_end, bi.fifo_data_start, bi.fifo_data, exp[9], exp[8], exp[7:0]);
         end
         bi.fifo_data_read = 1'b1;
         tick();
      end
      bi.fifo_data_read = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      assertions++;
      if ({bi.fifo_data_available, bi.wr_full, bi.wr_dropped, bs.fifo_data_available, bs.wr_full, bs.wr_dropped} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b%b%b %b%b%b, want 000 000", bi.fifo_data_available, bi.wr_full,
                  bi.wr_dropped, bs.fifo_data_available, bs.wr_full, bs.wr_dropped);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      wr_bytes(92, 8'h10, 0, 91);
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL avail_before_end: got %b want 0", bi.fifo_data_available);
      end
      wr_bytes(92, 8'h10, 91, 92);
      assertions++;
      if (bi.fifo_data_available !== 1'b1) begin
         failures++;
         $display("FAIL avail_after_end: got %b want 1", bi.fifo_data_available);
      end
      rd_bytes("frame92", 92, 8'h10, 0, 92);
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL avail_after_read: got %b want 0", bi.fifo_data_available);
      end
   endtask

   task automatic test_retry();
      wr_bytes(92, 8'h40, 0, 92);
      rd_bytes("retry_first", 92, 8'h40, 0, 40);
      bi.fifo_retry     = 1'b1;
      bi.fifo_data_read = 1'b1;
      tick();
      bi.fifo_retry     = 1'b0;
      bi.fifo_data_read = 1'b0;
      assertions++;
      if ({bi.fifo_data_start, bi.fifo_data} !== {1'b1, 8'h40}) begin
         failures++;
         $display("FAIL retry_rewind: got start %b data %h, want 1 40", bi.fifo_data_start, bi.fifo_data);
      end
      rd_bytes("retry_reread", 92, 8'h40, 0, 92);
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL retry_count_zero: avail %b want 0", bi.fifo_data_available);
      end
   endtask

   task automatic test_overflow();
      logic [9:0] exp;
      for (int i = 0; i < 20; i++) begin
         bs.wr_en    = 1'b1;
         bs.wr_start = (i == 0);
         bs.wr_end   = (i == 19);
         bs.wr_data  = 8'h70 + 8'(i);
         tick();
         if (i == 14 || i == 15) begin
            assertions++;
            if (bs.wr_full !== (i == 15)) begin
               failures++;
               $display("FAIL ovf_full after %0d writes: got %b want %b", i + 1, bs.wr_full, i == 15);
            end
         end
         if (i == 16 || i == 17) begin
            assertions++;
            if (bs.wr_dropped !== (i == 16)) begin
               failures++;
               $display("FAIL ovf_dropped after %0d writes: got %b want %b", i + 1, bs.wr_dropped, i == 16);
            end
         end
      end
      bs.wr_en = 1'b0;
      bs.wr_start = 1'b0;
      bs.wr_end = 1'b0;
      tick();
      assertions++;
      if ({bs.fifo_data_available, bs.wr_full} !== 2'b00) begin
         failures++;
         $display("FAIL ovf_after_drop: got avail %b full %b, want 0 0", bs.fifo_data_available, bs.wr_full);
      end
      for (int i = 0; i < 8; i++) begin
         bs.wr_en    = 1'b1;
         bs.wr_start = (i == 0);
         bs.wr_end   = (i == 7);
         bs.wr_data  = 8'hA0 + 8'(i);
         tick();
      end
      bs.wr_en = 1'b0;
      bs.wr_start = 1'b0;
      bs.wr_end = 1'b0;
      assertions++;
      if (bs.fifo_data_available !== 1'b1) begin
         failures++;
         $display("FAIL ovf_second_avail: got %b want 1", bs.fifo_data_available);
      end
      for (int i = 0; i < 8; i++) begin
         exp = {(i == 7), (i == 0), 8'hA0 + 8'(i)};
         assertions++;
         if ({bs.fifo_data_end, bs.fifo_data_start, bs.fifo_data} !== exp) begin
            failures++;
            $display("FAIL ovf_read byte %0d: got %b/%b/%h want %b/%b/%h", i, bs.fifo_data_end,
                     bs.fifo_data_start, bs.fifo_data, exp[9], exp[8], exp[7:0]);
         end
         bs.fifo_data_read = 1'b1;
         tick();
      end
      bs.fifo_data_read = 1'b0;
      assertions++;
      if (bs.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL ovf_final_avail: got %b want 0", bs.fifo_data_available);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp;
      wr_bytes(10, 8'h60, 0, 10);
      for (int c = 0; c < 10; c++) begin
         bi.wr_en    = (c < 5);
         bi.wr_start = (c == 0);
         bi.wr_end   = (c == 4);
         bi.wr_data  = 8'h80 + 8'(c);
         exp = {(c == 9), (c == 0), 8'h60 + 8'(c)};
         assertions++;
         if ({bi.fifo_data_end, bi.fifo_data_start, bi.fifo_data} !== exp) begin
            failures++;
            $display("FAIL b2b_A byte %0d: got %b/%b/%h want %b/%b/%h", c, bi.fifo_data_end,
                     bi.fifo_data_start, bi.fifo_data, exp[9], exp[8], exp[7:0]);
         end
         bi.fifo_data_read = 1'b1;
         tick();
      end
      bi.wr_en = 1'b0;
      bi.wr_start = 1'b0;
      bi.wr_end = 1'b0;
      bi.fifo_data_read = 1'b0;
      assertions++;
      if (bi.fifo_data_available !== 1'b1) begin
         failures++;
         $display("FAIL b2b_avail_after_A: got %b want 1", bi.fifo_data_available);
      end
      rd_bytes("b2b_B", 5, 8'h80, 0, 5);
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL b2b_avail_end: got %b want 0", bi.fifo_data_available);
      end
   endtask

   task automatic test_abort();
      wr_bytes(8, 8'hC0, 0, 3);
      assertions++;
      if (bi.wr_dropped !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_drop_yet: got %b want 0", bi.wr_dropped);
      end
      wr_bytes(6, 8'hD0, 0, 1);
      assertions++;
      if (bi.wr_dropped !== 1'b1) begin
         failures++;
         $display("FAIL abort_dropped: got %b want 1", bi.wr_dropped);
      end
      wr_bytes(6, 8'hD0, 1, 6);
      rd_bytes("abort_second", 6, 8'hD0, 0, 6);
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL abort_only_one: avail %b want 0", bi.fifo_data_available);
      end
   endtask

   task automatic test_async_reset();
      wr_bytes(60, 8'h20, 0, 60);
      rd_bytes("ar_partial", 60, 8'h20, 0, 25);
      #2 reset = 1'b0;
      #1;
      assertions++;
      if ({bi.fifo_data_available, bi.wr_full, bi.wr_dropped, bi.fifo_data_start, bi.fifo_data} !== {4'b0001, 8'h10}) begin
         failures++;
         $display("FAIL async_reset_outputs: got avail %b full %b drop %b start %b data %h, want 0 0 0 1 10",
                  bi.fifo_data_available, bi.wr_full, bi.wr_dropped, bi.fifo_data_start, bi.fifo_data);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL ar_avail_after_release: got %b want 0", bi.fifo_data_available);
      end
      wr_bytes(4, 8'hE0, 0, 4);
      rd_bytes("ar_new_frame", 4, 8'hE0, 0, 4);
      assertions++;
      if (bi.fifo_data_available !== 1'b0) begin
         failures++;
         $display("FAIL ar_final_avail: got %b want 0", bi.fifo_data_available);
      end
   endtask

   initial begin
      {bi.wr_data, bi.wr_start, bi.wr_end, bi.wr_en, bi.fifo_data_read, bi.fifo_retry} = '0;
      {bs.wr_data, bs.wr_start, bs.wr_end, bs.wr_en, bs.fifo_data_read, bs.fifo_retry} = '0;
      test_reset();
      test_single_frame();
      test_retry();
      test_overflow();
      test_back_to_back();
      test_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
